unary_stream_collector: RTL and testbench
=========================================

# unary_stream_collector

Receiving end of the unary bitstream interface driven by our unary arithmetic units (bit plus per-bit valid strobe). It consumes one unary stream of nominal length INPUT_WIDTH and tracks the running ones count. While bits arrive it exposes guaranteed lower and upper bounds on the final value. It terminates early once the bound interval is within tolerance, then holds a binary result under a valid/ack handshake for the downstream binary domain.

## Interface
- INPUT_WIDTH, 32, nominal stream length N (bits per value)
- COUNT_WIDTH, $clog2(INPUT_WIDTH + 1), width of all counts and bounds (holds 0..N)
- EPSILON, 0, early-termination tolerance; terminate when remaining bits ≤ 2·EPSILON
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin (or restart) collection of a new stream
- bit_in  in  1  unary stream bit
- bit_valid  in  1  bit_in is meaningful this cycle
- result_ack  in  1  downstream consumed the result
- ones_count  out  COUNT_WIDTH  ones accepted so far
- bits_seen  out  COUNT_WIDTH  bits accepted so far
- lower_bound  out  COUNT_WIDTH  = ones_count
- upper_bound  out  COUNT_WIDTH  = N − bits_seen + ones_count
- estimate  out  COUNT_WIDTH  = ones_count + ((N − bits_seen) >> 1)
- result_valid  out  1  result held, awaiting ack
- early_done  out  1  result produced before all N bits arrived
- busy  out  1  in COLLECT state
- drop_err  out  1  sticky: a valid bit arrived while not collecting

## Operation
- States: IDLE, COLLECT, HOLD. Reset → IDLE.
- Reset values: all outputs 0.
- IDLE:
  - start=1 → COLLECT. Clear ones_count, bits_seen, early_done and drop_err.
  - bit_valid=1 without start sets drop_err.
- COLLECT, busy=1:
  - bit_valid=1 → bits_seen+1, ones_count+bit_in.
  - Let rem = N − new bits_seen. If rem ≤ 2·EPSILON, go to HOLD on the same edge, set result_valid=1 and set early_done=(rem≠0).
  - start=1 restarts: counters cleared, the bit on that cycle is discarded, state stays COLLECT.
  - bit_valid=0 → no change; gaps of any length are allowed.
- HOLD:
  - Counters, bounds, estimate and early_done are frozen.
  - bit_valid=1 sets drop_err and the bit is discarded.
  - result_ack=1 → IDLE and result_valid=0.
  - result_ack=1 together with start=1 → COLLECT directly: counters cleared, drop_err cleared, result_valid=0.
  - start without ack is ignored.
- Bit acceptance on a start cycle: a bit presented in any state on a start cycle is never counted and never sets drop_err.
- Arithmetic:
  - All counts are unsigned COUNT_WIDTH.
  - bits_seen never exceeds N; ones_count never exceeds bits_seen.
  - upper_bound and estimate are combinational from the registered counters. Their intermediate sum fits in COUNT_WIDTH because ones_count ≤ bits_seen.
  - The EPSILON compare uses a COUNT_WIDTH+1 intermediate. EPSILON large enough that 2·EPSILON ≥ N terminates on the first accepted bit.

## Timing
- Bit accepted at edge t → counters and bounds updated and visible after edge t.
- Final bit accepted at edge t → result_valid=1 after edge t (zero extra latency). The result stays stable until ack.
- Ack sampled at edge t → result_valid=0 after edge t.
- Throughput: one bit per cycle. Back-to-back streams lose exactly one cycle (the start+ack cycle).
- Asynchronous reset mid-stream or mid-HOLD:
  - All state and outputs go to 0 immediately.
  - Collection resumes only on a new start.

## Test plan
- N=8, EPSILON=0, start then bits 1,0,1,1,0,1,0,0 on consecutive cycles → after the 8th edge: result_valid=1, ones_count=4, bits_seen=8, lower=upper=estimate=4, early_done=0.
- Same stream with bit_valid low on alternate cycles → identical result after 16 cycles. Mid-stream after 3 bits: lower=2, upper=7, estimate=4.
- N=8, EPSILON=1, bits 1,1,1,1,1,1 → terminate after the 6th bit: ones=6, lower=6, upper=8, estimate=7, early_done=1, busy=0.
- In HOLD, keep result_ack=0 for 5 cycles while driving bit_valid=1 → outputs frozen and drop_err=1. Then ack → IDLE next cycle, result_valid=0, drop_err still 1.
- In HOLD, assert start and result_ack together with bit_valid=1 → COLLECT, counters 0, drop_err 0, that bit not counted.
- Reset asserted after 3 accepted bits → all outputs 0 and IDLE. Bits without start set drop_err and leave counters 0.

Source files
------------

// File: rtl/unary_stream_collector.sv
// Receiving end of a unary bitstream: counts ones, exposes running bounds on the
// final value, terminates early within tolerance and holds the result for a valid/ack handshake.
module unary_stream_collector #(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int unsigned EPSILON     = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   bit_in_i,
    input  logic                   bit_valid_i,
    input  logic                   result_ack_i,
    output logic [COUNT_WIDTH-1:0] ones_count_o,
    output logic [COUNT_WIDTH-1:0] bits_seen_o,
    output logic [COUNT_WIDTH-1:0] lower_bound_o,
    output logic [COUNT_WIDTH-1:0] upper_bound_o,
    output logic [COUNT_WIDTH-1:0] estimate_o,
    output logic                   result_valid_o,
    output logic                   early_done_o,
    output logic                   busy_o,
    output logic                   drop_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    // Tolerance is saturated at N so an oversized EPSILON cannot wrap the compare width.
    localparam logic [COUNT_WIDTH:0]   N_EXT   = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] N_CNT   = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH:0]   TWO_EPS =
        ((64'(EPSILON) << 1) >= 64'(INPUT_WIDTH)) ? N_EXT : (COUNT_WIDTH + 1)'(EPSILON * 2);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] ones_q, ones_d;
    logic [COUNT_WIDTH-1:0] bits_q, bits_d;
    logic                   early_q, early_d;
    logic                   drop_q, drop_d;
    logic                   started_q, started_d;

    logic [COUNT_WIDTH-1:0] bitsInc;
    logic [COUNT_WIDTH-1:0] onesInc;
    logic [COUNT_WIDTH:0]   remAfter;
    logic                   withinTol;
    logic                   acceptStart;
    logic [COUNT_WIDTH-1:0] remaining;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            bits_q    <= '0;
            early_q   <= 1'b0;
            drop_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            bits_q    <= bits_d;
            early_q   <= early_d;
            drop_q    <= drop_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        bitsInc     = bits_q + COUNT_WIDTH'(1);
        onesInc     = ones_q + COUNT_WIDTH'(bit_in_i);
        remAfter    = N_EXT - {1'b0, bitsInc};
        withinTol   = (remAfter <= TWO_EPS);
        // A start in HOLD only counts when the result is being consumed on the same edge.
        acceptStart = start_i && ((state_q != HOLD) || result_ack_i);

        state_d   = state_q;
        ones_d    = ones_q;
        bits_d    = bits_q;
        early_d   = early_q;
        drop_d    = drop_q;
        started_d = started_q;

        if (bit_valid_i && !start_i && (state_q != COLLECT)) begin
            drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!start_i && bit_valid_i) begin
                    bits_d = bitsInc;
                    ones_d = onesInc;
                    if (withinTol) begin
                        state_d = HOLD;
                        early_d = (remAfter != '0);
                    end
                end
            end
            HOLD: begin
                if (result_ack_i) begin
                    state_d = start_i ? COLLECT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (acceptStart) begin
            ones_d    = '0;
            bits_d    = '0;
            early_d   = 1'b0;
            drop_d    = 1'b0;
            started_d = 1'b1;
        end
    end

    // Bounds stay at zero until the first stream begins so that reset leaves every output at 0.
    always_comb begin
        remaining     = N_CNT - bits_q;
        upper_bound_o = started_q ? (remaining + ones_q) : '0;
        estimate_o    = started_q ? (ones_q + (remaining >> 1)) : '0;
    end

    assign ones_count_o   = ones_q;
    assign bits_seen_o    = bits_q;
    assign lower_bound_o  = ones_q;
    assign result_valid_o = (state_q == HOLD);
    assign early_done_o   = early_q;
    assign busy_o         = (state_q == COLLECT);
    assign drop_err_o     = drop_q;

endmodule

// File: tb/tb_unary_stream_collector.sv
// Bench for unary_stream_collector: two instances (EPSILON 0 and 1, N=8) share one stimulus
// stream and are compared every cycle against a stream-level model plus literal anchors.
module tb_unary_stream_collector;

   localparam int N  = 8;
   localparam int CW = $clog2(N + 1);

   logic clk;
   logic rstN;
   logic startIn;
   logic bitIn;
   logic bitValid;
   logic resultAck;

   logic [CW-1:0] onesO  [2];
   logic [CW-1:0] seenO  [2];
   logic [CW-1:0] lowerO [2];
   logic [CW-1:0] upperO [2];
   logic [CW-1:0] estO   [2];
   logic          rvO    [2];
   logic          earlyO [2];
   logic          busyO  [2];
   logic          dropO  [2];

   int checkCount = 0;
   int failCount  = 0;
   bit checkEn    = 0;

   // Model state per instance: the tolerance each one was built with and what the stream has shown so far.
   int epsOf    [2] = '{0, 1};
   int mOnes    [2];
   int mSeen    [2];
   int mEarly   [2];
   int mDrop    [2];
   int mColl    [2];
   int mHold    [2];
   int mStarted [2];

   unary_stream_collector #(.INPUT_WIDTH(N), .COUNT_WIDTH(CW), .EPSILON(0)) dut0 (
      .clk_i(clk), .rst_ni(rstN), .start_i(startIn), .bit_in_i(bitIn),
      .bit_valid_i(bitValid), .result_ack_i(resultAck),
      .ones_count_o(onesO[0]), .bits_seen_o(seenO[0]), .lower_bound_o(lowerO[0]),
      .upper_bound_o(upperO[0]), .estimate_o(estO[0]), .result_valid_o(rvO[0]),
      .early_done_o(earlyO[0]), .busy_o(busyO[0]), .drop_err_o(dropO[0])
   );

   unary_stream_collector #(.INPUT_WIDTH(N), .COUNT_WIDTH(CW), .EPSILON(1)) dut1 (
      .clk_i(clk), .rst_ni(rstN), .start_i(startIn), .bit_in_i(bitIn),
      .bit_valid_i(bitValid), .result_ack_i(resultAck),
      .ones_count_o(onesO[1]), .bits_seen_o(seenO[1]), .lower_bound_o(lowerO[1]),
      .upper_bound_o(upperO[1]), .estimate_o(estO[1]), .result_valid_o(rvO[1]),
      .early_done_o(earlyO[1]), .busy_o(busyO[1]), .drop_err_o(dropO[1])
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mOnes[k] = 0; mSeen[k] = 0; mEarly[k] = 0; mDrop[k] = 0;
         mColl[k] = 0; mHold[k] = 0; mStarted[k] = 0;
      end
   endtask

   task automatic modelBegin(input int k);
      mOnes[k] = 0; mSeen[k] = 0; mEarly[k] = 0; mDrop[k] = 0;
      mColl[k] = 1; mHold[k] = 0; mStarted[k] = 1;
   endtask

   // Advance the model by one clock edge using the inputs presented for that edge.
   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         if (mHold[k] != 0) begin
            if (bitValid && !startIn) mDrop[k] = 1;
            if (resultAck) begin
               mHold[k] = 0;
               if (startIn) modelBegin(k);
            end
         end else if (mColl[k] != 0) begin
            if (startIn) begin
               modelBegin(k);
            end else if (bitValid) begin
               mSeen[k] = mSeen[k] + 1;
               mOnes[k] = mOnes[k] + (bitIn ? 1 : 0);
               if (N - mSeen[k] <= 2 * epsOf[k]) begin
                  mColl[k]  = 0;
                  mHold[k]  = 1;
                  mEarly[k] = (N - mSeen[k] != 0) ? 1 : 0;
               end
            end
         end else begin
            if (startIn) modelBegin(k);
            else if (bitValid) mDrop[k] = 1;
         end
      end
   endtask

   // Every cycle, both instances against the model; bounds come straight from their definitions.
   always @(negedge clk) begin
      if (checkEn) begin
         for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("dut%0d.ones", k),  int'(onesO[k]),  mOnes[k]);
            checkOutput($sformatf("dut%0d.seen", k),  int'(seenO[k]),  mSeen[k]);
            checkOutput($sformatf("dut%0d.lower", k), int'(lowerO[k]), mOnes[k]);
            checkOutput($sformatf("dut%0d.upper", k), int'(upperO[k]),
                        (mStarted[k] != 0) ? (N - mSeen[k] + mOnes[k]) : 0);
            checkOutput($sformatf("dut%0d.estimate", k), int'(estO[k]),
                        (mStarted[k] != 0) ? (mOnes[k] + (N - mSeen[k]) / 2) : 0);
            checkOutput($sformatf("dut%0d.result_valid", k), int'(rvO[k]), mHold[k]);
            checkOutput($sformatf("dut%0d.early_done", k), int'(earlyO[k]), mEarly[k]);
            checkOutput($sformatf("dut%0d.busy", k), int'(busyO[k]), mColl[k]);
            checkOutput($sformatf("dut%0d.drop_err", k), int'(dropO[k]), mDrop[k]);
         end
      end
   end

   task automatic applyStimulus(input bit st, input bit b, input bit bv, input bit ack);
      startIn   = st;
      bitIn     = b;
      bitValid  = bv;
      resultAck = ack;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   initial begin
      bit stream [8] = '{1, 0, 1, 1, 0, 1, 0, 0};

      rstN = 1'b0; startIn = 1'b0; bitIn = 1'b0; bitValid = 1'b0; resultAck = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      checkEn = 1;

      // Out of reset every output is zero.
      checkOutput("reset.upper", int'(upperO[0]), 0);
      checkOutput("reset.estimate", int'(estO[0]), 0);
      checkOutput("reset.busy", int'(busyO[0]), 0);

      // Contiguous stream; the EPSILON=1 instance finishes two bits early.
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, stream[i], 1, 0);
      checkOutput("full.result_valid", int'(rvO[0]), 1);
      checkOutput("full.ones", int'(onesO[0]), 4);
      checkOutput("full.seen", int'(seenO[0]), 8);
      checkOutput("full.upper", int'(upperO[0]), 4);
      checkOutput("full.estimate", int'(estO[0]), 4);
      checkOutput("full.early", int'(earlyO[0]), 0);
      checkOutput("full.eps1_early", int'(earlyO[1]), 1);

      // Same stream with a gap after every bit.
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, stream[i], 1, 0);
         if (i == 2) begin
            checkOutput("gap.mid_lower", int'(lowerO[0]), 2);
            checkOutput("gap.mid_upper", int'(upperO[0]), 7);
            checkOutput("gap.mid_estimate", int'(estO[0]), 4);
         end
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("gap.ones", int'(onesO[0]), 4);
      checkOutput("gap.result_valid", int'(rvO[0]), 1);

      // Back-to-back via start+ack, then six ones for early termination.
      applyStimulus(1, 0, 0, 1);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0);
      checkOutput("eps1.ones", int'(onesO[1]), 6);
      checkOutput("eps1.upper", int'(upperO[1]), 8);
      checkOutput("eps1.estimate", int'(estO[1]), 7);
      checkOutput("eps1.early", int'(earlyO[1]), 1);
      checkOutput("eps1.busy", int'(busyO[1]), 0);

      // Bits arriving while holding are dropped and flagged.
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
      checkOutput("hold.ones_frozen", int'(onesO[1]), 6);
      checkOutput("hold.drop", int'(dropO[1]), 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("ack.result_valid", int'(rvO[1]), 0);
      checkOutput("ack.drop_sticky", int'(dropO[1]), 1);

      // Start without ack in HOLD is ignored; start+ack with a bit discards that bit.
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("hold_start.result_valid", int'(rvO[0]), 1);
      applyStimulus(1, 1, 1, 1);
      checkOutput("restart.busy", int'(busyO[0]), 1);
      checkOutput("restart.seen", int'(seenO[0]), 0);
      checkOutput("restart.drop", int'(dropO[1]), 0);

      // Restart mid-collection, a few bits, then asynchronous reset.
      applyStimulus(0, 1, 1, 0);
      applyStimulus(1, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("pre_reset.seen", int'(seenO[0]), 3);
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset.seen", int'(seenO[0]), 0);
      checkOutput("async_reset.upper", int'(upperO[0]), 0);
      checkOutput("async_reset.busy", int'(busyO[0]), 0);
      #1 rstN = 1'b1;
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      checkOutput("post_reset.drop", int'(dropO[0]), 1);
      checkOutput("post_reset.ones", int'(onesO[0]), 0);
      applyStimulus(0, 0, 0, 0);

      checkEn = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
